// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - RV32M operation encoding and operand-class helpers for the mdu
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    function automatic logic op_is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_signed_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    function automatic logic op_a_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative RV32M multiply/divide unit with valid/ready request and result handshakes
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  mdu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

    mdu_state_t  state_q, state_d;
    mdu_op_t     op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] bop_q, bop_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;
    logic        res_valid_q, res_valid_d;

    logic        sign_a, sign_b, special;
    logic [31:0] mag_a, mag_b, special_res;
    logic [32:0] mul_sum, div_shift, div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Request decode: magnitudes, and the early-out cases that never enter CALC.
    always_comb begin
        sign_a      = op_a_signed(op) & a[31];
        sign_b      = op_b_signed(op) & b[31];
        mag_a       = sign_a ? (~a + 32'd1) : a;
        mag_b       = sign_b ? (~b + 32'd1) : b;
        special     = 1'b0;
        special_res = '0;
        if (op_is_div(op)) begin
            if (b == '0) begin
                special     = 1'b1;
                special_res = op_is_rem(op) ? a : '1;
            end else if (op_is_signed_div(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                special     = 1'b1;
                special_res = op_is_rem(op) ? '0 : 32'h8000_0000;
            end
        end
    end

    // The partial remainder stays below the divisor, so bit 32 of the trial is a clean borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bop_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_trial = div_shift - {1'b0, bop_q};
        prod_fix  = neg_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        bop_d       = bop_q;
        neg_d       = neg_q;
        result_d    = result_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (start_valid && !flush) begin
                    op_d  = op;
                    bop_d = mag_b;
                    acc_d = {32'd0, mag_a};
                    neg_d = op_is_rem(op) ? sign_a : (sign_a ^ sign_b);
                    cnt_d = 5'd31;
                    if (special) begin
                        result_d    = special_res;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (op_is_div(op_q)) begin
                    acc_d = {div_trial[32] ? div_shift[31:0] : div_trial[31:0],
                             acc_q[30:0], ~div_trial[32]};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!op_is_div(op_q)) begin
                    result_d = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
                end else begin
                    result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
                end
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            acc_q       <= '0;
            bop_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            bop_q       <= bop_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign result      = result_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu against an arithmetic RV32M reference model
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_valid, flush, res_ready;
    logic        start_ready, res_valid, busy;
    mdu_op_t     op;
    logic [31:0] a, b, result;

    int n_tests = 0;
    int n_fail  = 0;

    mdu dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .a(a), .b(b), .flush(flush), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic mdu_op_t rand_op();
        logic [2:0] t;
        t = 3'($urandom_range(0, 7));
        return mdu_op_t'(t);
    endfunction

    function automatic logic [31:0] ref_mdu(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (o)
            OP_MUL:    begin p = 64'(ux * uy); return p[31:0];  end
            OP_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            OP_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            OP_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
            OP_DIV:    return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            OP_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            OP_REM:    return (y == 0) ? x : 32'(sx % sy);
            default:   return (y == 0) ? x : 32'(ux % uy);
        endcase
    endfunction

    function automatic int ref_latency(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        if (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && y == 0) return 1;
        if (o inside {OP_DIV, OP_REM} && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issues one request and waits for its result; operands are scrambled right after accept.
    task automatic do_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y, input bit take,
                         output logic [31:0] r, output int lat);
        int guard = 0;
        while (!start_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        op = o; a = x; b = y; start_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; op = rand_op();
        while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = result;
        if (take) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
    endtask

    task automatic run_table(input string name, input mdu_op_t ops[4], input logic [31:0] xs[4], input logic [31:0] ys[4]);
        logic [31:0] r, exp;
        int lat, elat;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], xs[i], ys[i], 1'b1, r, lat);
            exp  = ref_mdu(ops[i], xs[i], ys[i]);
            elat = ref_latency(ops[i], xs[i], ys[i]);
            n_tests++;
            if (r !== exp) begin n_fail++; $display("FAIL %s_result[%0d] %s: got %h expected %h", name, i, ops[i].name(), r, exp); end
            n_tests++;
            if (lat != elat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat, elat); end
        end
    endtask

    task automatic test_mul();
        run_table("mul", '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU},
                  '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2});
    endtask

    task automatic test_div();
        run_table("div", '{OP_DIV, OP_REM, OP_DIVU, OP_REMU},
                  '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
                  '{32'd2, 32'd2, 32'd7, 32'd7});
    endtask

    task automatic test_special();
        run_table("special", '{OP_DIVU, OP_REM, OP_DIV, OP_REM},
                  '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000},
                  '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    endtask

    task automatic test_hold();
        logic [31:0] r, exp;
        int lat;
        exp = ref_mdu(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, r, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (result !== exp || res_valid !== 1'b1 || start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got result %h valid %b start_ready %b expected %h 1 0", i, result, res_valid, start_ready, exp);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_tests++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got start_ready %b valid %b expected 1 0", start_ready, res_valid);
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] r;
        int lat;
        bit seen;
        op = OP_DIVU; a = 32'd9; b = 32'd3; start_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accept: got busy %b start_ready %b expected 0 1", busy, start_ready); end

        op = OP_DIVU; a = 32'd100; b = 32'd7; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin n_fail++; $display("FAIL calc_busy: got busy %b start_ready %b expected 1 0", busy, start_ready); end
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_calc: got busy %b start_ready %b valid %b expected 0 1 0", busy, start_ready, res_valid);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL flush_no_result: got res_valid 1 expected 0"); end

        do_op(OP_MUL, 32'd3, 32'd5, 1'b0, r, lat);
        flush = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; res_ready = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done: got valid %b start_ready %b expected 0 1", res_valid, start_ready); end

        op = OP_MUL; a = 32'd11; b = 32'd13; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got busy %b start_ready %b valid %b result %h expected 0 1 0 00000000", busy, start_ready, res_valid, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL reset_no_result: got res_valid 1 expected 0"); end

        do_op(OP_DIVU, 32'd9, 32'd3, 1'b1, r, lat);
        n_tests++;
        if (r !== 32'd3 || lat != 34) begin n_fail++; $display("FAIL post_reset_divu: got %h lat %0d expected 00000003 lat 34", r, lat); end
    endtask

    task automatic test_random();
        logic [31:0] r, x, y, exp;
        mdu_op_t o;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            o = rand_op();
            x = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 100));
                default: y = 32'($urandom);
            endcase
            exp  = ref_mdu(o, x, y);
            elat = ref_latency(o, x, y);
            do_op(o, x, y, 1'b1, r, lat);
            n_tests++;
            if (r !== exp || lat != elat) begin
                n_fail++; $display("FAIL random[%0d] %s %h %h: got %h lat %0d expected %h lat %0d", i, o.name(), x, y, r, lat, exp, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, exp;
        int lat;
        for (int i = 0; i < 3; i++) begin
            exp = ref_mdu(OP_REM, 32'hFFFF_FF00 + 32'(i), 32'd10 + 32'(i));
            do_op(OP_REM, 32'hFFFF_FF00 + 32'(i), 32'd10 + 32'(i), 1'b1, r, lat);
            n_tests++;
            if (r !== exp || start_ready !== 1'b1) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got %h start_ready %b expected %h 1", i, r, start_ready, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
        op = OP_MUL; a = '0; b = '0;
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_flush_reset();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
